// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, word-wide memory between instruction fetch and load/store.
// Load/store has fixed priority, and a streak counter bounds how long a waiting fetch starves.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // Instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  // Load/store port
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [3:0]        ls_be,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ready,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  // Memory macro
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] StreakMax = 4'(STREAK_MAX);

  logic [3:0]        streak_q, streak_d;
  logic              gnt_if, gnt_ls, gnt_any;
  logic [ADDR_W-1:0] win_addr;
  logic              win_store, misal;
  logic              rsp_if_q, rsp_ls_q, rsp_err_q, rsp_store_q;

  // Grants are forced low during reset so nothing reaches the memory.
  always_comb begin
    gnt_if = 1'b0;
    gnt_ls = 1'b0;
    if (rst_n) begin
      if (ls_req && !(if_req && (streak_q == StreakMax))) begin
        gnt_ls = 1'b1;
      end else if (if_req) begin
        gnt_if = 1'b1;
      end
    end
    gnt_any   = gnt_if | gnt_ls;
    win_addr  = gnt_ls ? ls_addr : if_addr;
    win_store = gnt_ls & ls_we;
    misal     = gnt_any && (win_addr[1:0] != 2'b00);
  end

  assign if_ready = gnt_if;
  assign ls_ready = gnt_ls;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_any && !misal) begin
      mem_en    = 1'b1;
      mem_addr  = win_addr;
      mem_we    = win_store;
      mem_be    = win_store ? ls_be : 4'hF;
      mem_wdata = win_store ? ls_wdata : '0;
    end
  end

  // Counts LS wins over a waiting fetch; any other cycle restarts the streak.
  always_comb begin
    streak_d = 4'd0;
    if (gnt_ls && if_req) begin
      streak_d = (streak_q == StreakMax) ? streak_q : streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q    <= 4'd0;
      rsp_if_q    <= 1'b0;
      rsp_ls_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_store_q <= 1'b0;
    end else begin
      streak_q    <= streak_d;
      rsp_if_q    <= gnt_if;
      rsp_ls_q    <= gnt_ls;
      rsp_err_q   <= misal;
      rsp_store_q <= win_store;
    end
  end

  assign if_rvalid = rsp_if_q;
  assign if_err    = rsp_if_q & rsp_err_q;
  assign if_rdata  = (rsp_if_q && !rsp_err_q) ? mem_rdata : '0;

  assign ls_rvalid = rsp_ls_q;
  assign ls_err    = rsp_ls_q & rsp_err_q;
  assign ls_rdata  = (rsp_ls_q && !rsp_err_q && !rsp_store_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a reference model predicts grants and responses; a monitor checks rvalids.
module tb_mem_port_arbiter;

  localparam int unsigned STREAK_MAX = 4;

  logic        clk, rst_n;
  logic        if_req, if_ready, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_ready, ls_rvalid, ls_err;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STREAK_MAX(STREAK_MAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ready (if_ready),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .if_err   (if_err),
    .ls_req   (ls_req),
    .ls_we    (ls_we),
    .ls_be    (ls_be),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_ready (ls_ready),
    .ls_rvalid(ls_rvalid),
    .ls_rdata (ls_rdata),
    .ls_err   (ls_err),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_be   (mem_be),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t        if_q[$];
  rsp_t        ls_q[$];
  logic [31:0] tb_mem [64];
  logic [31:0] ref_mem[64];
  int          cyc;
  int          n_tests, n_fail;
  logic [3:0]  m_streak;
  logic [15:0] gnt_hist;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural memory target: samples on posedge, data valid next cycle.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) tb_mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= tb_mem[mem_addr[7:2]];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_rvalid) begin
        if (if_q.size() == 0) begin
          check("if_unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = if_q.pop_front();
          check("if_rsp_cycle", cyc, e.cyc);
          check("if_rdata", if_rdata, e.data);
          check("if_err", {31'd0, if_err}, {31'd0, e.err});
        end
      end else begin
        check("if_idle_rdata", if_rdata, 32'd0);
        if (if_q.size() != 0 && if_q[0].cyc <= cyc) begin
          check("if_missing_rvalid", 32'd0, 32'd1);
          void'(if_q.pop_front());
        end
      end
      if (ls_rvalid) begin
        if (ls_q.size() == 0) begin
          check("ls_unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = ls_q.pop_front();
          check("ls_rsp_cycle", cyc, e.cyc);
          check("ls_rdata", ls_rdata, e.data);
          check("ls_err", {31'd0, ls_err}, {31'd0, e.err});
        end
      end else begin
        check("ls_idle_rdata", ls_rdata, 32'd0);
        if (ls_q.size() != 0 && ls_q[0].cyc <= cyc) begin
          check("ls_missing_rvalid", 32'd0, 32'd1);
          void'(ls_q.pop_front());
        end
      end
    end
  end

  // One request cycle: drive, check combinational outputs against the model, predict response.
  task automatic step(input logic ireq, input logic [31:0] iaddr, input logic lreq,
                      input logic lwe, input logic [3:0] lbe, input logic [31:0] laddr,
                      input logic [31:0] lwdata);
    logic        g_if, g_ls, al, st;
    logic [31:0] a;
    rsp_t        r;
    if_req = ireq; if_addr = iaddr;
    ls_req = lreq; ls_we = lwe; ls_be = lbe; ls_addr = laddr; ls_wdata = lwdata;
    @(negedge clk);
    g_if = ireq && (!lreq || m_streak == 4'(STREAK_MAX));
    g_ls = lreq && !g_if;
    gnt_hist = {gnt_hist[14:0], ls_ready};
    check("if_ready", {31'd0, if_ready}, {31'd0, g_if});
    check("ls_ready", {31'd0, ls_ready}, {31'd0, g_ls});
    a  = g_ls ? laddr : iaddr;
    al = (a[1:0] == 2'b00);
    st = g_ls && lwe;
    check("mem_en", {31'd0, mem_en}, {31'd0, (g_if || g_ls) && al});
    if ((g_if || g_ls) && al) begin
      check("mem_addr", mem_addr, a);
      check("mem_we", {31'd0, mem_we}, {31'd0, st});
      check("mem_be", {28'd0, mem_be}, st ? {28'd0, lbe} : 32'hF);
      if (st) check("mem_wdata", mem_wdata, lwdata);
    end
    r.cyc  = cyc + 1;
    r.err  = !al;
    r.data = (al && !st) ? ref_mem[a[7:2]] : 32'd0;
    if (g_if) if_q.push_back(r);
    if (g_ls) ls_q.push_back(r);
    if (st && al) begin
      for (int b = 0; b < 4; b++) begin
        if (lbe[b]) ref_mem[a[7:2]][8*b +: 8] = lwdata[8*b +: 8];
      end
    end
    m_streak = (g_ls && ireq) ? m_streak + 4'd1 : 4'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; m_streak = 4'd0; gnt_hist = '0;
    mem_rdata = '0;
    for (int i = 0; i < 64; i++) begin
      tb_mem[i]  = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      ref_mem[i] = tb_mem[i];
    end
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h0;
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'h0; ls_addr = 32'h4; ls_wdata = '0;
    #3;
    check("rst_if_ready", {31'd0, if_ready}, 32'd0);
    check("rst_ls_ready", {31'd0, ls_ready}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    check("rst_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single fetch of preloaded word.
    step(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle();

    // Contention: LS x4 then forced IF, twice.
    gnt_hist = '0;
    for (int i = 0; i < 10; i++) step(1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    check("grant_sequence", {22'd0, gnt_hist[9:0]}, 32'b1111011110);
    idle();

    // Store, load, byte-lane store, reload.
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'h1, 32'h10, 32'h000000AA);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    check("ref_merge", ref_mem[4], 32'hDEADBEAA);

    // Misaligned fetch and load.
    step(1'b1, 32'h2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h13, 32'h0);
    idle();

    // Back-to-back fetches.
    step(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle();

    // Reset right after a contended LS load grant drops its response and the streak.
    step(1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    step(1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    rst_n = 1'b0;
    if_q.delete(); ls_q.delete();
    m_streak = 4'd0;
    if_req = 1'b0; ls_req = 1'b0;
    #1;
    check("rstmid_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
    @(negedge clk);
    check("rstmid_ls_rvalid_hold", {31'd0, ls_rvalid}, 32'd0);
    check("rstmid_streak", {28'd0, dut.streak_q}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_rst_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
    step(1'b1, 32'hC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    gnt_hist = '0;
    for (int i = 0; i < 5; i++) step(1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    check("post_rst_grants", {27'd0, gnt_hist[4:0]}, 32'b11110);
    idle();
    idle();
    check("if_queue_drained", if_q.size(), 32'd0);
    check("ls_queue_drained", ls_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, byte-addressed, word-wide memory between the instruction-fetch unit (IF port) and the load/store unit (LS port).
- Target memory samples `en`/`addr` on posedge `clk` and returns the little-endian word one cycle later.
- Block sits between the core pipeline and the memory macro.
- Provides:
  - per-port request/ready handshakes;
  - fixed LS priority with bounded fetch starvation;
  - misalignment checking;
  - response routing.

Parameters:
- ADDR_W, 32, address width for both ports and the memory.
- DATA_W, 32, word width; fixed at 32 (4 byte lanes).
- STREAK_MAX, 4, max consecutive LS grants while IF is waiting before IF is forced a grant; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request valid
- if_addr  in  ADDR_W  fetch byte address
- if_ready  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch response valid (registered)
- if_rdata  out  DATA_W  fetch data
- if_err  out  1  fetch misaligned; qualified by if_rvalid
- ls_req  in  1  load/store request valid
- ls_we  in  1  1 = store, 0 = load
- ls_be  in  4  store byte enables, bit i = byte lane i
- ls_addr  in  ADDR_W  load/store byte address
- ls_wdata  in  DATA_W  store data
- ls_ready  out  1  LS request accepted this cycle (combinational)
- ls_rvalid  out  1  LS response/ack valid (registered)
- ls_rdata  out  DATA_W  load data
- ls_err  out  1  LS misaligned; qualified by ls_rvalid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_be  out  4  memory byte enables
- mem_addr  out  ADDR_W  memory byte address (word aligned)
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en

Behaviour:
- **Clock and reset**
  - Single clock.
  - rst_n low (asynchronous) clears: `if_rvalid`, `ls_rvalid`, the response-owner register, the error flags and `streak_cnt`, all to 0.
  - Combinational outputs (`if_ready`, `ls_ready`, `mem_*`) are 0 whenever rst_n is low.
- **Arbitration (combinational, each cycle)**
  - Only IF requesting: grant IF.
  - Only LS requesting: grant LS.
  - Both requesting: grant LS unless `streak_cnt == STREAK_MAX`, in which case grant IF.
  - No request: no grant; all `mem_*` outputs 0.
  - The port's `*_ready` is high exactly in its grant cycle. The request is accepted on that edge.
  - Requesters hold `req` and payload stable until ready.
- **Streak counter (4 bits)**
  - Increments when LS is granted while `if_req` is high.
  - Clears when IF is granted or `if_req` is low.
  - Saturates at STREAK_MAX.
- **Issue**
  - Granted aligned request (`addr[1:0] == 0`): drive `mem_en = 1`, plus `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` from the winner.
  - For IF, and for LS loads: `mem_we = 0` and `mem_be = 4'hF`.
- **Misaligned request** (`addr[1:0] != 0`)
  - Still granted (ready high) and still consumes the arbitration slot and streak logic.
  - `mem_en` is held 0.
  - Next cycle: the port's `rvalid = 1`, `err = 1`, `rdata = 0`.
- **Response (latency 1)**
  - Owner and error flag are registered at the grant edge.
  - In cycle N+1 the owner's `rvalid` is high for exactly one cycle.
  - Load/fetch: `rdata = mem_rdata` (combinational pass-through).
  - Store: `ls_rvalid` is an acknowledge, with `ls_rdata = 0` and `ls_err = 0`.
  - The non-owner's `rdata` is 0.
- **Throughput**
  - Fully pipelined: one grant per cycle.
  - A new grant in cycle N+1 overlaps the response of cycle N.
  - No back-pressure on responses; requesters must always accept rvalid.
- **Reset mid-operation**
  - Any in-flight response is dropped (no rvalid after reset release).
  - The first grant is possible in the first cycle with rst_n high.
- **Address arithmetic**
  - No increment or wrap is performed by this block.
  - Addresses pass through unmodified. Wrap at 2^ADDR_W is the memory's concern.

Test Plan:
1. Memory preloaded bytes 00,01,02,03 at 0x0. IF req addr 0x0 alone -> if_ready same cycle, mem_en=1, mem_addr=0x0; next cycle if_rvalid=1, if_rdata=0x03020100, if_err=0.
2. Contention, STREAK_MAX=4, if_req and ls_req both held high for 10 cycles -> grant sequence LS,LS,LS,LS,IF,LS,LS,LS,LS,IF; each rvalid lands one cycle after its grant.
3. Store 0xDEADBEEF, be=4'hF at 0x10, then load 0x10 -> store ack ls_rvalid=1 with ls_rdata=0; load returns 0xDEADBEEF. Then store 0x000000AA with be=4'h1 and reload -> 0xDEADBEAA.
4. Misaligned: if_addr=0x2 -> if_ready=1, mem_en=0; next cycle if_rvalid=1, if_err=1, if_rdata=0. ls_addr=0x13 load -> ls_err=1 the same way.
5. Back-to-back IF fetches 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive if_rvalid cycles, data in order.
6. Assert rst_n low one cycle after an LS load grant -> ls_rvalid stays 0 and streak_cnt=0; after release, a new IF request is granted in the first cycle.
